// File: rtl/turbo_deinterleaver_pkg.sv
// turbo_pkg: QPP block sizes, coefficients, FSM states and modular-add helpers
package turbo_pkg;
    localparam int K_MAX   = 6144;
    localparam int K_SMALL = 1056;
    localparam int ADDR_W  = 13;
    localparam int F1_1056 = 17;
    localparam int F2_1056 = 66;
    localparam int F1_6144 = 263;
    localparam int F2_6144 = 480;
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_e;
    function automatic logic [ADDR_W-1:0] k_len(input logic k6144);
        return k6144 ? ADDR_W'(K_MAX) : ADDR_W'(K_SMALL);
    endfunction
    function automatic logic [ADDR_W-1:0] qpp_g0(input logic k6144);
        return k6144 ? ADDR_W'((F1_6144 + F2_6144) % K_MAX) : ADDR_W'((F1_1056 + F2_1056) % K_SMALL);
    endfunction
    function automatic logic [ADDR_W-1:0] qpp_step(input logic k6144);
        return k6144 ? ADDR_W'((2 * F2_6144) % K_MAX) : ADDR_W'((2 * F2_1056) % K_SMALL);
    endfunction
    // both operands are below k, so one conditional subtract reduces the sum
    function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] s;
        logic [ADDR_W:0] d;
        s = {1'b0, a} + {1'b0, b};
        d = s - {1'b0, k};
        return (s >= {1'b0, k}) ? d[ADDR_W-1:0] : s[ADDR_W-1:0];
    endfunction
endpackage

// File: rtl/turbo_deinterleaver_if.sv
// turbo_deint_if: bit-serial input and byte output handshakes of the deinterleaver
interface turbo_deint_if;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       k_size_6144;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       block_done;
    modport master (
        output bit_in, bit_valid, k_size_6144, byte_ready,
        input  bit_ready, byte_out, byte_valid, busy, block_done
    );
    modport slave (
        input  bit_in, bit_valid, k_size_6144, byte_ready,
        output bit_ready, byte_out, byte_valid, busy, block_done
    );
endinterface

// File: rtl/turbo_deinterleaver_qpp_addr_gen.sv
// qpp_addr_gen: multiplier-free QPP address sequence pi(j) with end-of-block flag
module qpp_addr_gen
    import turbo_pkg::*;
(
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic              k_sel,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic              k_q;
    logic [ADDR_W-1:0] pi_q;
    logic [ADDR_W-1:0] g_q;
    logic [ADDR_W-1:0] j_q;
    // start consumes j=0 (address 0), so the registers load the j=1 terms
    always_ff @(posedge clock) begin
        if (rst) begin
            k_q  <= 1'b0;
            pi_q <= '0;
            g_q  <= '0;
            j_q  <= '0;
        end else if (start) begin
            k_q  <= k_sel;
            pi_q <= qpp_g0(k_sel);
            g_q  <= mod_add(qpp_g0(k_sel), qpp_step(k_sel), k_len(k_sel));
            j_q  <= ADDR_W'(1);
        end else if (advance) begin
            pi_q <= mod_add(pi_q, g_q, k_len(k_q));
            g_q  <= mod_add(g_q, qpp_step(k_q), k_len(k_q));
            j_q  <= j_q + 1'b1;
        end
    end
    assign addr = pi_q;
    assign last = j_q == k_len(k_q) - 1'b1;
endmodule

// File: rtl/turbo_deinterleaver.sv
// turbo_deinterleaver: writes interleaved bits to QPP addresses, drains natural-order bytes
// Optional TURBO_DEINT_BYPASS_EN adds a bypass input selecting identity addressing.
module turbo_deinterleaver
    import turbo_pkg::*;
(
    input  logic clock,
    input  logic rst,
`ifdef TURBO_DEINT_BYPASS_EN
    input  logic bypass,
`endif
    turbo_deint_if.slave io
);
    state_e            state_q;
    logic [K_MAX-1:0]  mem_q;
    logic [9:0]        b_q;
    logic              k_q;
    logic              bit_ready_q;
    logic              byte_valid_q;
    logic              busy_q;
    logic              bit_acc;
    logic              byte_acc;
    logic              start;
    logic              advance;
    logic              last;
    logic              byte_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [ADDR_W-1:0] wr_addr;
    assign bit_acc   = io.bit_valid & bit_ready_q;
    assign byte_acc  = byte_valid_q & io.byte_ready;
    assign start     = bit_acc & (state_q == IDLE);
    assign advance   = bit_acc & (state_q == FILL);
    assign byte_last = b_q == (k_q ? 10'd767 : 10'd131);
    qpp_addr_gen u_gen (
        .clock   (clock),
        .rst     (rst),
        .start   (start),
        .advance (advance),
        .k_sel   (io.k_size_6144),
        .addr    (gen_addr),
        .last    (last)
    );
`ifdef TURBO_DEINT_BYPASS_EN
    logic              byp_q;
    logic [ADDR_W-1:0] j_q;
    always_ff @(posedge clock) begin
        if (rst) begin
            byp_q <= 1'b0;
            j_q   <= '0;
        end else if (start) begin
            byp_q <= bypass;
            j_q   <= ADDR_W'(1);
        end else if (advance) begin
            j_q   <= j_q + 1'b1;
        end
    end
    assign wr_addr = (state_q == IDLE) ? '0 : byp_q ? j_q : gen_addr;
`else
    assign wr_addr = (state_q == IDLE) ? '0 : gen_addr;
`endif
    always_ff @(posedge clock) begin
        if (bit_acc) mem_q[wr_addr] <= io.bit_in;
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_ready_q  <= 1'b1;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            b_q          <= '0;
            k_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bit_acc) begin
                    state_q <= FILL;
                    busy_q  <= 1'b1;
                    k_q     <= io.k_size_6144;
                end
                FILL: if (bit_acc && last) begin
                    state_q      <= DRAIN;
                    bit_ready_q  <= 1'b0;
                    byte_valid_q <= 1'b1;
                    b_q          <= '0;
                end
                DRAIN: if (byte_acc) begin
                    b_q <= b_q + 1'b1;
                    if (byte_last) begin
                        state_q      <= IDLE;
                        byte_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        bit_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign io.bit_ready  = bit_ready_q;
    assign io.byte_valid = byte_valid_q;
    assign io.busy       = busy_q;
    assign io.byte_out   = byte_valid_q ? mem_q[{b_q, 3'b000} +: 8] : 8'd0;
    assign io.block_done = byte_acc & byte_last;
endmodule

// File: tb/tb_turbo_deinterleaver.sv
// tb_turbo_deinterleaver: directed and round-trip checks of the QPP deinterleaver
module tb_turbo_deinterleaver;
    logic clock = 1'b0;
    logic rst = 1'b1;
    logic bypass = 1'b0;
    int checks = 0;
    int failures = 0;
    bit stream [0:6143];
    logic [7:0] exp_b [0:767];
    always #5 clock = ~clock;
    turbo_deint_if io();
    turbo_deinterleaver dut (
        .clock (clock),
        .rst   (rst),
`ifdef TURBO_DEINT_BYPASS_EN
        .bypass(bypass),
`endif
        .io    (io)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int pi_f(input bit k6, input int j);
        longint f1, f2, k, jj;
        f1 = k6 ? 263 : 17;
        f2 = k6 ? 480 : 66;
        k  = k6 ? 6144 : 1056;
        jj = longint'(j);
        return int'((f1 * jj + f2 * jj * jj) % k);
    endfunction
    task automatic clear_all();
        for (int i = 0; i < 6144; i++) stream[i] = 1'b0;
        for (int i = 0; i < 768; i++) exp_b[i] = 8'h00;
    endtask
    task automatic build_rt(input bit k6);
        int k;
        k = k6 ? 6144 : 1056;
        for (int i = 0; i < k / 8; i++) exp_b[i] = 8'($urandom_range(0, 255));
        for (int j = 0; j < k; j++) begin
            int p;
            p = pi_f(k6, j);
            stream[j] = exp_b[p / 8][p % 8];
        end
    endtask
    task automatic send(input bit k6, input int n, input bit toggle, input bit gaps);
        for (int j = 0; j < n; j++) begin
            @(negedge clock);
            while (gaps && $urandom_range(0, 3) == 0) begin
                io.bit_valid = 1'b0;
                @(negedge clock);
            end
            io.bit_valid = 1'b1;
            io.bit_in = stream[j];
            io.k_size_6144 = (toggle && j > 0) ? (k6 ^ (j % 2 == 1)) : k6;
            #1;
            if (!io.bit_ready) begin
                check($sformatf("bit_ready j=%0d", j), io.bit_ready, 1);
                io.bit_valid = 1'b0;
                return;
            end
            @(posedge clock);
        end
    endtask
    task automatic drain(input int nbytes, input bit stall, input bit hold, input string tag);
        int idx, cyc;
        logic [7:0] held;
        bit stalled, rdy_seen;
        idx = 0; cyc = 0; held = 8'h00; stalled = 0; rdy_seen = 0;
        while (idx < nbytes && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            io.bit_valid = hold;
            io.byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 1) check({tag, " first_valid"}, io.byte_valid, 1);
            if (io.bit_ready) rdy_seen = 1;
            if (io.byte_valid) begin
                if (stalled) check({tag, " stable"}, io.byte_out, held);
                if (io.byte_ready) begin
                    check($sformatf("%s byte%0d", tag, idx), io.byte_out, exp_b[idx]);
                    check($sformatf("%s done%0d", tag, idx), io.block_done, idx == nbytes - 1);
                    idx++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = io.byte_out;
                end
            end
        end
        check({tag, " count"}, idx, nbytes);
        @(negedge clock);
        io.byte_ready = 1'b1;
        io.bit_valid = 1'b0;
        #1;
        check({tag, " valid_after"}, io.byte_valid, 0);
        check({tag, " busy_after"}, io.busy, 0);
        check({tag, " ready_after"}, io.bit_ready, 1);
        check({tag, " ready_in_drain"}, rdy_seen, 0);
    endtask
    initial begin
        io.bit_in = 1'b0;
        io.bit_valid = 1'b0;
        io.k_size_6144 = 1'b0;
        io.byte_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst byte_out", io.byte_out, 0);
        check("rst byte_valid", io.byte_valid, 0);
        check("rst busy", io.busy, 0);
        check("rst block_done", io.block_done, 0);
        check("rst bit_ready", io.bit_ready, 1);
        rst = 1'b0;
        // single 1 at j=1, K=1056: pi(1)=83 -> byte 10 bit 3
        clear_all();
        stream[1] = 1'b1;
        exp_b[10] = 8'h08;
        send(1'b0, 1056, 1'b0, 1'b0);
        drain(132, 1'b0, 1'b0, "k1056_j1");
        // single 1 at j=2, K=1056: pi(2)=298 -> byte 37 bit 2
        clear_all();
        stream[2] = 1'b1;
        exp_b[37] = 8'h04;
        send(1'b0, 1056, 1'b0, 1'b1);
        drain(132, 1'b0, 1'b0, "k1056_j2");
        // single 1 at j=1, K=6144: pi(1)=743 -> byte 92 bit 7
        clear_all();
        stream[1] = 1'b1;
        exp_b[92] = 8'h80;
        send(1'b1, 6144, 1'b0, 1'b0);
        drain(768, 1'b0, 1'b0, "k6144_j1");
        clear_all();
        build_rt(1'b0);
        send(1'b0, 1056, 1'b0, 1'b1);
        drain(132, 1'b1, 1'b0, "rt1056");
        clear_all();
        build_rt(1'b1);
        send(1'b1, 6144, 1'b0, 1'b1);
        drain(768, 1'b1, 1'b0, "rt6144");
        // abort a 6144 block part-way, then a clean 1056 block
        clear_all();
        build_rt(1'b1);
        send(1'b1, 500, 1'b0, 1'b0);
        @(negedge clock);
        io.bit_valid = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        #1;
        check("abort busy", io.busy, 0);
        check("abort byte_valid", io.byte_valid, 0);
        check("abort bit_ready", io.bit_ready, 1);
        clear_all();
        build_rt(1'b0);
        send(1'b0, 1056, 1'b0, 1'b0);
        drain(132, 1'b1, 1'b0, "post_abort");
        clear_all();
        build_rt(1'b0);
        send(1'b0, 1056, 1'b1, 1'b0);
        drain(132, 1'b1, 1'b1, "ksel_toggle");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
